// File: rtl/display_scanner.sv
// Four-digit common-anode seven-segment scanner. Values are staged in a pending
// register and only reach the display register at the frame wrap, so a frame never shows a mix of old and new digits.
module display_scanner #(
    parameter int PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_done,
    output logic        pend
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          wrap;

    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend_q;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;

    logic [3:0]    nibble;
    logic          lead_zero;
    logic          blank;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= 2'd0;
            pend_val <= 16'h0000;
            pend_dp  <= 4'h0;
            pend_q   <= 1'b0;
            disp_val <= 16'h0000;
            disp_dp  <= 4'h0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // Commit uses the pre-edge pending contents, so a simultaneous load waits a frame.
            if (wrap && pend_q) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_q   <= 1'b1;
            end else if (wrap) begin
                pend_q   <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        nibble    = disp_val[3:0];
        lead_zero = 1'b0;
        case (idx)
            2'd0: begin
                nibble    = disp_val[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                nibble    = disp_val[7:4];
                lead_zero = (disp_val[15:4] == 12'h000);
            end
            2'd2: begin
                nibble    = disp_val[11:8];
                lead_zero = (disp_val[15:8] == 8'h00);
            end
            default: begin
                nibble    = disp_val[15:12];
                lead_zero = (disp_val[15:12] == 4'h0);
            end
        endcase
    end

    // blank_lz is deliberately live so software can toggle it without a reload.
    assign blank = blank_lz && lead_zero;

    always_comb begin
        an  = 4'b1111;
        seg = 7'b1111111;
        dp  = 1'b1;
        if (!blank) begin
            an  = ~(4'b0001 << idx);
            seg = hex_to_seg(nibble);
            dp  = ~disp_dp[idx];
        end
    end

    assign digit_sel  = idx;
    assign frame_done = wrap;
    assign pend       = pend_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: directed table vectors plus random traffic checked
// every cycle against a time-based model, on a PRESCALE=4 and a PRESCALE=1 instance.
module tb_display_scanner;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [1:0]  sel0, sel1;
    logic        fd0, fd1;
    logic        pend0, pend1;

    display_scanner #(.PRESCALE(4)) dut0 (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .an(an0), .seg(seg0), .dp(dp0),
        .digit_sel(sel0), .frame_done(fd0), .pend(pend0)
    );

    display_scanner #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .an(an1), .seg(seg1), .dp(dp1),
        .digit_sel(sel1), .frame_done(fd1), .pend(pend1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    logic [6:0] hexlut [16];

    // Model: cycle count since reset plus pending/display contents.
    int          pr [2] = '{4, 1};
    int          mt [2];
    logic        mpend [2];
    logic [15:0] mpv [2];
    logic [15:0] mdv [2];
    logic [3:0]  mpdp [2];
    logic [3:0]  mdp [2];
    logic        model_ok = 1'b0;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            blz;
        logic [3:0][6:0] seg;
        logic [3:0][3:0] an;
        logic [3:0]      dpo;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s p%0d: got %h want %h at %0t", nm, pr[k], act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mt[k]    = 0;
                mpend[k] = 1'b0;
                mpv[k]   = 16'h0;
                mdv[k]   = 16'h0;
                mpdp[k]  = 4'h0;
                mdp[k]   = 4'h0;
            end else if (model_ok) begin
                if ((mt[k] % (4 * pr[k])) == (4 * pr[k] - 1) && mpend[k]) begin
                    mdv[k]   = mpv[k];
                    mdp[k]   = mpdp[k];
                    mpend[k] = 1'b0;
                end
                if (load) begin
                    mpv[k]   = value;
                    mpdp[k]  = dp_in;
                    mpend[k] = 1'b1;
                end
                mt[k]++;
            end
        end
        if (rst) model_ok = 1'b1;
    endtask

    task automatic model_check();
        int         d;
        logic       efd;
        logic       blank;
        logic [15:0] upper;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        if (!model_ok) return;
        for (int k = 0; k < 2; k++) begin
            d     = (mt[k] / pr[k]) % 4;
            efd   = (mt[k] % (4 * pr[k])) == (4 * pr[k] - 1);
            upper = mdv[k] >> (4 * d);
            blank = blank_lz && (d > 0) && (upper == 16'h0);
            ea    = blank ? 4'b1111 : ~(4'b0001 << d);
            es    = blank ? 7'b1111111 : hexlut[upper[3:0]];
            ed    = blank ? 1'b1 : ~mdp[k][d];
            chk("m_an",   k, (k == 0) ? 16'(an0)   : 16'(an1),   16'(ea));
            chk("m_seg",  k, (k == 0) ? 16'(seg0)  : 16'(seg1),  16'(es));
            chk("m_dp",   k, (k == 0) ? 16'(dp0)   : 16'(dp1),   16'(ed));
            chk("m_sel",  k, (k == 0) ? 16'(sel0)  : 16'(sel1),  16'(d));
            chk("m_fd",   k, (k == 0) ? 16'(fd0)   : 16'(fd1),   16'(efd));
            chk("m_pend", k, (k == 0) ? 16'(pend0) : 16'(pend1), 16'(mpend[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    task automatic wait_fd0();
        int n;
        n = 0;
        while (!fd0 && n < 20) begin
            step();
            n++;
        end
        chk("fd_wait", 0, 16'(fd0), 16'h1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int c;
        rst = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
        hexlut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        tbl[0] = '{16'h12AF, 4'b0100, 1'b0,
                   {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110},
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1011};
        tbl[1] = '{16'h0005, 4'b0000, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010},
                   {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b1111};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
                   {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b1111};
        tbl[3] = '{16'h0305, 4'b1001, 1'b1,
                   {7'b1111111, 7'b0110000, 7'b1000000, 7'b0010010},
                   {4'b1111, 4'b1011, 4'b1101, 4'b1110}, 4'b1110};
        tbl[4] = '{16'hC4B7, 4'b1111, 1'b0,
                   {7'b1000110, 7'b0011001, 7'b0000011, 7'b1111000},
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b0000};
        tbl[5] = '{16'h0D90, 4'b0000, 1'b0,
                   {7'b1000000, 7'b0100001, 7'b0010000, 7'b1000000},
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111};

        // Reset held for three cycles, then released.
        repeat (3) begin
            step();
            chk("rst_an",   0, 16'(an0),   16'h000E);
            chk("rst_seg",  0, 16'(seg0),  16'h0040);
            chk("rst_dp",   0, 16'(dp0),   16'h0001);
            chk("rst_pend", 0, 16'(pend0), 16'h0000);
            chk("rst_fd",   0, 16'(fd0),   16'h0000);
        end
        rst = 1'b0;
        chk("rel_an",  0, 16'(an0),  16'h000E);
        chk("rel_seg", 0, 16'(seg0), 16'h0040);
        chk("rel_sel", 0, 16'(sel0), 16'h0000);

        // First frame_done lands on cycle 15, scan wraps to digit 0 on 16.
        c = 0;
        while (!fd0 && c < 40) begin
            step();
            c++;
        end
        chk("first_fd_cycle", 0, 16'(c), 16'd15);
        step();
        chk("wrap_sel", 0, 16'(sel0), 16'h0000);
        chk("wrap_an",  0, 16'(an0),  16'h000E);

        // Table vectors; first load lands at cycle 5 after a fresh reset.
        do_reset();
        repeat (5) step();
        for (int v = 0; v < 6; v++) begin
            blank_lz = tbl[v].blz;
            value    = tbl[v].value;
            dp_in    = tbl[v].dp;
            load     = 1'b1;
            step();
            load     = 1'b0;
            chk("tbl_pend", 0, 16'(pend0), 16'h0001);
            wait_fd0();
            step();
            for (int d = 0; d < 4; d++) begin
                chk("tbl_sel", 0, 16'(sel0), 16'(d));
                chk("tbl_an",  0, 16'(an0),  16'(tbl[v].an[d]));
                chk("tbl_seg", 0, 16'(seg0), 16'(tbl[v].seg[d]));
                chk("tbl_dp",  0, 16'(dp0),  16'(tbl[v].dpo[d]));
                repeat (4) step();
            end
        end

        // Last load wins; a load on the frame_done cycle waits one frame.
        blank_lz = 1'b0;
        do_reset();
        repeat (2) step();
        value = 16'h1111; dp_in = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        repeat (2) step();
        value = 16'h2222; load = 1'b1;
        step();
        load = 1'b0;
        wait_fd0();
        value = 16'h3333; load = 1'b1;
        step();
        load = 1'b0;
        chk("coll_pend",  0, 16'(pend0), 16'h0001);
        chk("coll_seg22", 0, 16'(seg0),  16'h0024);
        wait_fd0();
        step();
        chk("coll_seg33", 0, 16'(seg0),  16'h0030);
        chk("coll_pend0", 0, 16'(pend0), 16'h0000);

        // Reset at cycle 9 discards a pending load.
        do_reset();
        repeat (2) step();
        value = 16'hBEEF; dp_in = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        repeat (6) step();
        do_reset();
        chk("mid_pend", 0, 16'(pend0), 16'h0000);
        chk("mid_sel",  0, 16'(sel0),  16'h0000);
        chk("mid_an",   0, 16'(an0),   16'h000E);
        wait_fd0();
        step();
        chk("mid_seg",  0, 16'(seg0),  16'h0040);
        chk("mid_dp",   0, 16'(dp0),   16'h0001);

        // Random traffic, checked every cycle against the model.
        repeat (1500) begin
            rst   = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 7) == 0);
            value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            step();
        end
        rst  = 1'b0;
        load = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
